// File: rtl/sdpram_stream_reader.sv
// sdpram_stream_reader
// Read-side master for the single-clock simple dual-port RAM. Issues
// sequential reads from a base address for a given word count and presents
// the returned words as a valid/ready stream. A credit-controlled skid
// buffer of LAT+1 entries hides the RAM read latency (LAT = 1, or 2 when
// OUTPUT_REG = "TRUE") so one word per cycle is sustained under READY_I=1.
//
// Optional feature: define SDPRAM_STREAM_READER_ABORT_EN to add ABORT_I,
// which cancels a running transfer, flushes buffered and in-flight data and
// returns to idle without a DONE_O pulse.

module sdpram_stream_reader #(
   parameter int    DATA_WIDTH = 8,
   parameter int    ADDR_WIDTH = 9,
   parameter string OUTPUT_REG = "FALSE"
) (
   input  logic                  CLK_I,
   input  logic                  RST_I,
   input  logic                  START_I,
   input  logic [ADDR_WIDTH-1:0] BASE_ADDR_I,
   input  logic [ADDR_WIDTH:0]   LENGTH_I,
   output logic                  BUSY_O,
   output logic                  DONE_O,
   output logic [ADDR_WIDTH-1:0] RADDR_O,
   output logic                  RENABLE_O,
   input  logic [DATA_WIDTH-1:0] RDATA_I,
   output logic [DATA_WIDTH-1:0] DATA_O,
   output logic                  VALID_O,
   input  logic                  READY_I,
   output logic                  LAST_O
`ifdef SDPRAM_STREAM_READER_ABORT_EN
   ,
   input  logic                  ABORT_I
`endif
);

   // Read latency of the RAM and the buffer depth needed to cover it.
   localparam int LAT   = (OUTPUT_REG == "TRUE") ? 2 : 1;
   localparam int DEPTH = LAT + 1;
   // Storage is sized to the pointer range; only DEPTH entries are used.
   localparam int PW    = 2;
   localparam int BUF_N = 4;
   // Occupancy counters hold 0..DEPTH (at most 3).
   localparam int CW    = 3;

   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   ONE_LEN  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH:0]     len_q, len_d;
   logic [ADDR_WIDTH:0]     issued_q, issued_d;
   logic [ADDR_WIDTH:0]     accepted_q, accepted_d;
   logic [LAT-1:0]          vpipe_q, vpipe_d;
   logic [DATA_WIDTH-1:0]   buf_q [BUF_N];
   logic [DATA_WIDTH-1:0]   buf_d [BUF_N];
   logic [PW-1:0]           wptr_q, wptr_d;
   logic [PW-1:0]           rptr_q, rptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic                    abort_s;
   logic                    ren_s;
   logic                    flush_s;
   logic                    valid_s;
   logic                    last_s;
   logic                    pop_s;
   logic                    push_s;
   logic [CW-1:0]           inflight_s;
   logic [CW-1:0]           occ_s;
   logic [LAT-1:0]          vshift_s;

`ifdef SDPRAM_STREAM_READER_ABORT_EN
   assign abort_s = ABORT_I;
`else
   assign abort_s = 1'b0;
`endif

   // Circular pointer advance over the DEPTH used buffer entries.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + {{(PW-1){1'b0}}, 1'b1};
      end
   endfunction

   // Next-state, read issue with credit check, capture pipeline and FIFO update.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      issued_d   = issued_q;
      accepted_d = accepted_q;
      ren_s      = 1'b0;
      flush_s    = 1'b0;

      inflight_s = {CW{1'b0}};
      for (int i = 0; i < LAT; i++) begin
         inflight_s = inflight_s + CW'(vpipe_q[i]);
      end

      valid_s = (count_q != {CW{1'b0}});
      last_s  = valid_s && ((accepted_q + ONE_LEN) == len_q);
      pop_s   = valid_s && READY_I;
      // Outstanding words after this edge if nothing new were issued.
      occ_s   = inflight_s + count_q - CW'(pop_s);

      case (state_q)
         ST_IDLE: begin
            if (START_I) begin
               addr_d     = BASE_ADDR_I;
               len_d      = LENGTH_I;
               issued_d   = {(ADDR_WIDTH+1){1'b0}};
               accepted_d = {(ADDR_WIDTH+1){1'b0}};
               if (LENGTH_I == {(ADDR_WIDTH+1){1'b0}}) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort_s) begin
               flush_s = 1'b1;
               state_d = ST_IDLE;
            end else begin
               ren_s      = (issued_q < len_q) && (occ_s < CW'(DEPTH));
               addr_d     = ren_s ? (addr_q + ONE_ADDR) : addr_q;
               issued_d   = ren_s ? (issued_q + ONE_LEN) : issued_q;
               accepted_d = pop_s ? (accepted_q + ONE_LEN) : accepted_q;
               if (pop_s && last_s) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Valid-shift pipeline: bit LAT-1 marks data arriving on RDATA_I now.
      vshift_s    = vpipe_q;
      vshift_s[0] = ren_s;
      for (int i = 1; i < LAT; i++) begin
         vshift_s[i] = vpipe_q[i-1];
      end
      vpipe_d = flush_s ? {LAT{1'b0}} : vshift_s;
      push_s  = vpipe_q[LAT-1] && !flush_s;

      buf_d = buf_q;
      if (push_s) begin
         buf_d[wptr_q] = RDATA_I;
      end else begin
         buf_d[wptr_q] = buf_q[wptr_q];
      end

      if (flush_s) begin
         wptr_d  = {PW{1'b0}};
         rptr_d  = {PW{1'b0}};
         count_d = {CW{1'b0}};
      end else begin
         wptr_d  = push_s ? ptr_inc(wptr_q) : wptr_q;
         rptr_d  = pop_s ? ptr_inc(rptr_q) : rptr_q;
         count_d = count_q + CW'(push_s) - CW'(pop_s);
      end

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_FIN);
   end

   // State, counters, capture pipeline and buffer registers with synchronous reset.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q    <= ST_IDLE;
         addr_q     <= {ADDR_WIDTH{1'b0}};
         len_q      <= {(ADDR_WIDTH+1){1'b0}};
         issued_q   <= {(ADDR_WIDTH+1){1'b0}};
         accepted_q <= {(ADDR_WIDTH+1){1'b0}};
         vpipe_q    <= {LAT{1'b0}};
         for (int i = 0; i < BUF_N; i++) begin
            buf_q[i] <= {DATA_WIDTH{1'b0}};
         end
         wptr_q     <= {PW{1'b0}};
         rptr_q     <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         accepted_q <= accepted_d;
         vpipe_q    <= vpipe_d;
         buf_q      <= buf_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign BUSY_O    = busy_q;
   assign DONE_O    = done_q;
   assign RADDR_O   = addr_q;
   assign RENABLE_O = ren_s;
   assign DATA_O    = buf_q[rptr_q];
   assign VALID_O   = valid_s;
   assign LAST_O    = last_s;

endmodule
